// File: rtl/img_frame_buf.sv
// Dual-port frame buffer. Port A is a streaming frame writer with a
// length/ready/done handshake. Port B is a random-access read/write port
// with a registered read, out-of-range flag and collision flag.
module img_frame_buf #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 6400,
  parameter int unsigned ADDR_W   = 13,
  parameter bit          READ_NEW = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_frame_len,
  input  logic              i_wr_start,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_frame_done,
  output logic [ADDR_W-1:0] o_wr_count,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_data_b,
  input  logic              i_we_b,
  output logic [DATA_W-1:0] o_q_b,
  output logic              o_oor_b,
  output logic              o_collision
);

  // One extra bit so a frame length equal to 2**ADDR_W stays representable.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic [CNT_W-1:0]    w_len_sel;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_wr_count;
  logic                r_wr_ready;
  logic                r_frame_done;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_b_in_range;
  logic [ADDR_W-1:0]   w_a_addr;
  logic                w_b_hit;
  logic [DATA_W-1:0]   w_mem_rd;
  logic [DATA_W-1:0]   w_q_nxt;
  logic [DATA_W-1:0]   r_q_b;
  logic                r_oor_b;
  logic                r_collision;

  // Writer next state: wr_start wins everywhere, pixels only accepted in FILL.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_len_sel   = {1'b0, i_frame_len};
    if ((i_frame_len == '0) || ({1'b0, i_frame_len} > DEPTH_C)) begin
      w_len_sel = DEPTH_C;
    end
    if (i_wr_start) begin
      w_state_nxt = S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          if (i_wr_valid) begin
            w_accept = 1'b1;
            if ((r_wr_count + CNT_W'(1)) == r_len) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Writer state, length latch, pixel counter and handshake flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_len        <= DEPTH_C;
      r_wr_count   <= '0;
      r_wr_ready   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ready   <= (w_state_nxt == S_FILL);
      r_frame_done <= (w_state_nxt == S_DONE);
      if (i_wr_start) begin
        r_len      <= w_len_sel;
        r_wr_count <= '0;
      end else if (w_accept) begin
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  // Port B decode: range check, A/B address match and next read data.
  always_comb begin
    w_b_in_range = ({1'b0, i_addr_b} < DEPTH_C);
    w_a_addr     = r_wr_count[ADDR_W-1:0];
    w_b_hit      = w_accept && w_b_in_range && (w_a_addr == i_addr_b);
    w_mem_rd     = r_mem[i_addr_b];
    w_q_nxt      = '0;
    if (w_b_in_range) begin
      if (i_we_b) begin
        w_q_nxt = READ_NEW ? i_data_b : w_mem_rd;
      end else if (w_b_hit) begin
        w_q_nxt = READ_NEW ? i_wr_data : w_mem_rd;
      end else begin
        w_q_nxt = w_mem_rd;
      end
    end
  end

  // RAM array; port B is written last so it wins a same-address write.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[w_a_addr] <= i_wr_data;
    end
    if (i_we_b && w_b_in_range) begin
      r_mem[i_addr_b] <= i_data_b;
    end
  end

  // Port B registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q_b       <= '0;
      r_oor_b     <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_q_b       <= w_q_nxt;
      r_oor_b     <= !w_b_in_range;
      r_collision <= w_b_hit;
    end
  end

  assign o_wr_ready   = r_wr_ready;
  assign o_frame_done = r_frame_done;
  assign o_wr_count   = r_wr_count[ADDR_W-1:0];
  assign o_q_b        = r_q_b;
  assign o_oor_b      = r_oor_b;
  assign o_collision  = r_collision;

endmodule

// File: tb/tb_img_frame_buf.sv
// Scoreboarded bench for img_frame_buf, run against both READ_NEW settings.
module tb_img_frame_buf;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 6400;
  localparam int unsigned AW    = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] frame_len;
  logic          wr_start;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic          we_b;

  logic          wr_ready,  wr_ready0;
  logic          frame_done, frame_done0;
  logic [AW-1:0] wr_count,  wr_count0;
  logic [DW-1:0] q_b,       q_b0;
  logic          oor_b,     oor_b0;
  logic          collision, collision0;

  img_frame_buf #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_NEW(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_len(frame_len), .i_wr_start(wr_start),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_frame_done(frame_done), .o_wr_count(wr_count), .i_addr_b(addr_b),
    .i_data_b(data_b), .i_we_b(we_b), .o_q_b(q_b), .o_oor_b(oor_b),
    .o_collision(collision)
  );

  img_frame_buf #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_NEW(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_frame_len(frame_len), .i_wr_start(wr_start),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready0),
    .o_frame_done(frame_done0), .o_wr_count(wr_count0), .i_addr_b(addr_b),
    .i_data_b(data_b), .i_we_b(we_b), .o_q_b(q_b0), .o_oor_b(oor_b0),
    .o_collision(collision0)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Bench-side model of RAM contents and writer state.
  logic [DW-1:0] mdl [DEPTH];
  int            exp_cnt;
  int            m_len;
  logic          m_fill;

  // Scoreboard queues for port B results.
  logic [DW-1:0] sb_q1 [$];
  logic [DW-1:0] sb_q0 [$];
  logic          sb_oor [$];
  logic          sb_col [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // One port-B access; expectations are pushed, then popped after the edge.
  task automatic b_access(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
    logic          in_r, a_wr, hit;
    logic [DW-1:0] old, nw, e1, e0;
    logic          eo, ec;
    in_r = (int'(a) < DEPTH);
    a_wr = wr_valid && m_fill && !wr_start;
    old  = in_r ? mdl[a] : '0;
    hit  = a_wr && in_r && (a == exp_cnt[AW-1:0]);
    nw   = !in_r ? '0 : (we ? d : (hit ? wr_data : old));
    sb_q1.push_back(nw);
    sb_q0.push_back(old);
    sb_oor.push_back(!in_r);
    sb_col.push_back(hit);
    if (a_wr) begin
      mdl[exp_cnt] = wr_data;
      exp_cnt++;
      if (exp_cnt == m_len) m_fill = 1'b0;
    end
    if (we && in_r) mdl[a] = d;
    addr_b = a; data_b = d; we_b = we;
    @(posedge clk); #1;
    we_b = 1'b0;
    e1 = sb_q1.pop_front();
    e0 = sb_q0.pop_front();
    eo = sb_oor.pop_front();
    ec = sb_col.pop_front();
    n_chk += 4;
    if (q_b !== e1) begin
      n_err++; $display("FAIL q_b_new addr=%0d got=%h exp=%h", a, q_b, e1);
    end
    if (q_b0 !== e0) begin
      n_err++; $display("FAIL q_b_old addr=%0d got=%h exp=%h", a, q_b0, e0);
    end
    if (oor_b !== eo) begin
      n_err++; $display("FAIL oor_b addr=%0d got=%b exp=%b", a, oor_b, eo);
    end
    if (collision !== ec) begin
      n_err++; $display("FAIL collision addr=%0d got=%b exp=%b", a, collision, ec);
    end
  endtask

  task automatic start_frame(input int len);
    frame_len = AW'(len); wr_start = 1'b1; wr_valid = 1'b0;
    @(posedge clk); #1;
    wr_start = 1'b0;
    m_fill   = 1'b1;
    exp_cnt  = 0;
    m_len    = (len == 0 || len > int'(DEPTH)) ? int'(DEPTH) : len;
    n_chk += 3;
    if (wr_ready !== 1'b1) begin
      n_err++; $display("FAIL start_ready got=%b exp=1", wr_ready);
    end
    if (frame_done !== 1'b0) begin
      n_err++; $display("FAIL start_done got=%b exp=0", frame_done);
    end
    if (wr_count !== '0) begin
      n_err++; $display("FAIL start_count got=%0d exp=0", wr_count);
    end
  endtask

  // Drive one accepted pixel; wr_valid is left high for the caller.
  task automatic px(input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    n_chk++;
    if (wr_ready !== m_fill) begin
      n_err++; $display("FAIL px_ready got=%b exp=%b", wr_ready, m_fill);
    end
    mdl[exp_cnt] = d;
    exp_cnt++;
    if (exp_cnt == m_len) m_fill = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_chk += 7;
    if (wr_ready !== 1'b0)   begin n_err++; $display("FAIL rst_ready got=%b exp=0", wr_ready); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    if (wr_count !== '0)     begin n_err++; $display("FAIL rst_count got=%0d exp=0", wr_count); end
    if (q_b !== '0)          begin n_err++; $display("FAIL rst_q got=%h exp=0", q_b); end
    if (oor_b !== 1'b0)      begin n_err++; $display("FAIL rst_oor got=%b exp=0", oor_b); end
    if (collision !== 1'b0)  begin n_err++; $display("FAIL rst_col got=%b exp=0", collision); end
    if (q_b0 !== '0)         begin n_err++; $display("FAIL rst_q0 got=%h exp=0", q_b0); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stream4();
    logic [DW-1:0] pix [4];
    pix[0] = 8'h11; pix[1] = 8'h22; pix[2] = 8'h33; pix[3] = 8'h44;
    start_frame(4);
    for (int i = 0; i < 4; i++) px(pix[i]);
    wr_valid = 1'b0;
    n_chk += 3;
    if (wr_ready !== 1'b0)   begin n_err++; $display("FAIL s4_ready got=%b exp=0", wr_ready); end
    if (frame_done !== 1'b1) begin n_err++; $display("FAIL s4_done got=%b exp=1", frame_done); end
    if (wr_count !== AW'(4)) begin n_err++; $display("FAIL s4_count got=%0d exp=4", wr_count); end
    for (int i = 0; i < 4; i++) b_access(AW'(i), '0, 1'b0);
  endtask

  task automatic test_full_frame();
    int stalls;
    stalls = 0;
    start_frame(0);
    wr_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_data = DW'(i) ^ 8'h5A;
      if (wr_ready !== 1'b1) stalls++;
      mdl[i] = wr_data;
      @(posedge clk); #1;
    end
    exp_cnt = int'(DEPTH);
    m_fill  = 1'b0;
    n_chk += 4;
    if (stalls != 0)             begin n_err++; $display("FAIL ff_stalls got=%0d exp=0", stalls); end
    if (frame_done !== 1'b1)     begin n_err++; $display("FAIL ff_done got=%b exp=1", frame_done); end
    if (wr_ready !== 1'b0)       begin n_err++; $display("FAIL ff_ready got=%b exp=0", wr_ready); end
    if (wr_count !== AW'(DEPTH)) begin n_err++; $display("FAIL ff_count got=%0d exp=%0d", wr_count, DEPTH); end
    wr_data = 8'hEE;
    b_access('0, '0, 1'b0);
    wr_valid = 1'b0;
    n_chk++;
    if (wr_count !== AW'(DEPTH)) begin n_err++; $display("FAIL ff_count2 got=%0d exp=%0d", wr_count, DEPTH); end
  endtask

  task automatic test_rdw();
    b_access(AW'(10), 8'h55, 1'b1);
    b_access(AW'(10), 8'hAB, 1'b1);
    b_access(AW'(10), '0, 1'b0);
  endtask

  task automatic test_oor();
    b_access(AW'(6400), 8'h12, 1'b1);
    b_access(AW'(6399), '0, 1'b0);
    b_access(AW'(8191), 8'h34, 1'b1);
    b_access(AW'(0), '0, 1'b0);
  endtask

  task automatic test_collision();
    start_frame(8);
    for (int i = 0; i < 5; i++) px(8'hA0 + DW'(i));
    n_chk++;
    if (wr_count !== AW'(5)) begin n_err++; $display("FAIL col_count got=%0d exp=5", wr_count); end
    wr_data = 8'h77;
    b_access(AW'(5), 8'h99, 1'b1);
    wr_data = 8'h66;
    b_access(AW'(6), '0, 1'b0);
    wr_valid = 1'b0;
    b_access(AW'(5), '0, 1'b0);
    b_access(AW'(6), '0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    start_frame(10);
    px(8'hC1); px(8'hC2); px(8'hC3);
    wr_data = 8'hC4;
    rst = 1'b1;
    m_fill = 1'b0;
    #1;
    n_chk += 3;
    if (wr_ready !== 1'b0)   begin n_err++; $display("FAIL rm_ready got=%b exp=0", wr_ready); end
    if (wr_count !== '0)     begin n_err++; $display("FAIL rm_count got=%0d exp=0", wr_count); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL rm_done got=%b exp=0", frame_done); end
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) b_access(AW'(i), '0, 1'b0);
    start_frame(2);
    px(8'hD0);
    wr_valid = 1'b0;
    n_chk++;
    if (wr_count !== AW'(1)) begin n_err++; $display("FAIL rm_count2 got=%0d exp=1", wr_count); end
    b_access(AW'(0), '0, 1'b0);
    b_access(AW'(1), '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
    rst = 1'b1; frame_len = '0; wr_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
    addr_b = '0; data_b = '0; we_b = 1'b0;
    exp_cnt = 0; m_len = int'(DEPTH); m_fill = 1'b0;
    test_reset();
    test_stream4();
    test_full_frame();
    test_rdw();
    test_oor();
    test_collision();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/img_frame_buf.md
Name: img_frame_buf

Overview:
- Parametrised dual-port frame buffer that generalises the single-image output RAM.
- Port A is a streaming write port for one frame:
  - writer FSM with an auto-incrementing address, frame length and ready/done handshake.
- Port B is a random-access read/write port with a registered read.
  - Read-during-write mode is selectable.
  - Out-of-range accesses are flagged.
- Sits between the downsample datapath (producer on A) and the memory/DDR transfer logic (consumer on B).

Parameters:
- DATA_W, 8, pixel width in bits
- DEPTH, 6400, number of words (an 80x80 frame)
- ADDR_W, 13, address width; DEPTH <= 2**ADDR_W
- READ_NEW, 1, port B read-during-own-write: 1 = q_b returns data_b, 0 = q_b returns old contents

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_len  in  ADDR_W  pixels per frame, sampled on wr_start
- wr_start  in  1  pulse: arm writer, pointer to 0
- wr_valid  in  1  pixel present on wr_data
- wr_data  in  DATA_W  pixel to store
- wr_ready  out  1  writer accepts a pixel this cycle
- frame_done  out  1  sticky: frame fully written
- wr_count  out  ADDR_W  pixels written in current frame
- addr_b  in  ADDR_W  port B address
- data_b  in  DATA_W  port B write data
- we_b  in  1  port B write enable
- q_b  out  DATA_W  port B registered read data
- oor_b  out  1  registered: last addr_b was >= DEPTH
- collision  out  1  registered: A write and B access hit the same address

Behaviour:
- Reset (asynchronous, while rst=1): state=IDLE, wr_ready=0, frame_done=0, wr_count=0, q_b=0, oor_b=0, collision=0. RAM contents are not cleared.
- Writer FSM states:
  - IDLE: wr_ready=0.
    - wr_start -> FILL.
    - Latch len = (frame_len==0 || frame_len>DEPTH) ? DEPTH : frame_len.
    - Clear wr_count and frame_done.
  - FILL: wr_ready=1.
    - A pixel is accepted when wr_valid && wr_ready; it is written to ram[wr_count] in that cycle and wr_count increments.
    - When the accepted pixel makes wr_count==len, go to DONE. frame_done=1 and wr_ready=0 from the next cycle.
  - DONE: wr_ready=0; frame_done holds at 1.
    - wr_start -> FILL with a fresh latch and wr_count=0. frame_done drops to 0 the cycle after wr_start.
- wr_start in FILL restarts the frame: pointer to 0, len relatched. The pixel on wr_valid in that cycle is discarded.
- wr_start has priority over wr_valid in every state.
- wr_valid while wr_ready=0 is ignored; no write occurs and no error is raised.
- Port B, one cycle latency:
  - If we_b and addr_b<DEPTH: ram[addr_b]<=data_b; q_b <= READ_NEW ? data_b : old ram[addr_b].
  - If !we_b and addr_b<DEPTH: q_b <= ram[addr_b].
  - If addr_b>=DEPTH: no write; q_b<=0; oor_b<=1. Otherwise oor_b<=0.
- Same-cycle A write and B access to the same in-range address:
  - collision<=1 for one cycle; otherwise collision<=0.
  - If both write, the RAM keeps data_b (port B wins).
  - If B only reads, q_b follows the READ_NEW rule, treating the A write as the write.
- Reset mid-FILL: FSM returns to IDLE and pixels already written remain in RAM. A new wr_start is required.
- Width rules:
  - wr_count never exceeds len and never wraps.
  - Address comparisons are unsigned on ADDR_W bits.

Test Plan:
- rst; wr_start with frame_len=4; stream 0x11,0x22,0x33,0x44 with wr_valid held high -> wr_ready high 4 cycles then 0; frame_done=1 one cycle after the 4th pixel; wr_count=4; B reads of addr 0..3 return 0x11..0x44 one cycle after each address.
- frame_len=0, DEPTH=6400 -> len=6400; after 6400 pixels frame_done=1; a further wr_valid leaves ram[0] unchanged and wr_count=6400.
- Port B we_b=1, addr_b=10, data_b=0xAB, ram[10]=0x55 -> q_b=0xAB when READ_NEW=1 and 0x55 when READ_NEW=0; a later read of addr 10 returns 0xAB in both modes.
- addr_b=6400 with we_b=1 -> oor_b=1, q_b=0, no write anywhere; addr_b=6399 next cycle -> oor_b=0.
- In FILL with wr_count=5, drive wr_valid=1 with wr_data=0x77 and we_b=1, addr_b=5, data_b=0x99 in the same cycle -> collision=1 for one cycle; a later read of addr 5 returns 0x99.
- Assert rst asynchronously mid-FILL at wr_count=3 -> wr_ready and wr_count drop to 0 immediately; ram[0..2] still hold their pixels; after wr_start a new frame writes from address 0.
